// File: rtl/fontrom_pkg.sv
// Shared types and helpers for the font ROM arbiter: slot owner tags,
// host FSM states and font ROM geometry.
package fontrom_pkg;

    localparam int GLYPH_ROWS  = 16;
    localparam int FONT_ADDR_W = 12;
    localparam int FONT_DATA_W = 8;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        DISP = 2'd1,
        HOST = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } host_state_e;

    function automatic logic [FONT_ADDR_W-1:0] glyph_addr(input logic [7:0] ch,
                                                          input logic [3:0] row);
        return {ch, row};
    endfunction

endpackage

// File: rtl/fontrom_arb.sv
// Font ROM arbiter/sequencer: display fetches have strict priority, the host
// read port uses idle slots only. FONTROM_ARB_HIGH_BLANK_EN blanks codes 0x80-0xFF.
module fontrom_arb
    import fontrom_pkg::*;
#(
    parameter int STARVE_LIMIT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   disp_req,
    input  logic [7:0]             disp_char,
    input  logic [3:0]             disp_row,
    output logic                   disp_valid,
    output logic [FONT_DATA_W-1:0] disp_data,
    input  logic                   host_req,
    input  logic [FONT_ADDR_W-1:0] host_addr,
    output logic                   host_ack,
    output logic [FONT_DATA_W-1:0] host_data,
    output logic                   host_starved,
    output logic [FONT_ADDR_W-1:0] rom_addr,
    input  logic [FONT_DATA_W-1:0] rom_data
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    host_state_e            state_q, state_d;
    owner_e                 tag0_q, tag0_d, tag1_q;
    logic [FONT_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]             starve_q, starve_d;
    logic                   starved_q, starved_d;
    logic                   disp_valid_q, disp_valid_d;
    logic                   host_ack_q, host_ack_d;
    logic [FONT_DATA_W-1:0] disp_data_q, disp_data_d;
    logic [FONT_DATA_W-1:0] host_data_q, host_data_d;
    logic                   host_grant;
    logic                   blank0_d, blank0_q, blank1_q;

    // Slot decision and host FSM
    always_comb begin
        rom_addr_d = rom_addr_q;
        tag0_d     = NONE;
        state_d    = state_q;
        host_grant = 1'b0;
        blank0_d   = 1'b0;

        if (disp_req) begin
            rom_addr_d = glyph_addr(disp_char, disp_row);
            tag0_d     = DISP;
`ifdef FONTROM_ARB_HIGH_BLANK_EN
            blank0_d   = disp_char[7];
`endif
        end else if (state_q == IDLE && host_req) begin
            rom_addr_d = host_addr;
            tag0_d     = HOST;
            host_grant = 1'b1;
        end

        case (state_q)
            IDLE:    if (host_grant) state_d = WAIT;
            WAIT:    if (tag1_q == HOST) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Starvation tracking: only counts cycles the display actually took from a waiting host
    always_comb begin
        starve_d = starve_q;
        if (!host_req || host_grant)
            starve_d = 8'd0;
        else if (state_q == IDLE && disp_req && starve_q != 8'hFF)
            starve_d = starve_q + 8'd1;
        starved_d = (starve_d >= LIMIT);
    end

    // Data return at the end of the two-stage tag pipeline
    always_comb begin
        disp_valid_d = (tag1_q == DISP);
        host_ack_d   = (tag1_q == HOST);
        disp_data_d  = disp_data_q;
        host_data_d  = host_data_q;
        if (disp_valid_d) disp_data_d = blank1_q ? '0 : rom_data;
        if (host_ack_d)   host_data_d = rom_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tag0_q       <= NONE;
            tag1_q       <= NONE;
            blank0_q     <= 1'b0;
            blank1_q     <= 1'b0;
            rom_addr_q   <= '0;
            starve_q     <= 8'd0;
            starved_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            host_ack_q   <= 1'b0;
            disp_data_q  <= '0;
            host_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            tag0_q       <= tag0_d;
            tag1_q       <= tag0_q;
            blank0_q     <= blank0_d;
            blank1_q     <= blank0_q;
            rom_addr_q   <= rom_addr_d;
            starve_q     <= starve_d;
            starved_q    <= starved_d;
            disp_valid_q <= disp_valid_d;
            host_ack_q   <= host_ack_d;
            disp_data_q  <= disp_data_d;
            host_data_q  <= host_data_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign disp_valid   = disp_valid_q;
    assign disp_data    = disp_data_q;
    assign host_ack     = host_ack_q;
    assign host_data    = host_data_q;
    assign host_starved = starved_q;

endmodule

// File: tb/tb_fontrom_arb.sv
// Directed self-checking bench for fontrom_arb with a behavioural registered font ROM.
module tb_fontrom_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_req;
    logic [7:0]  disp_char;
    logic [3:0]  disp_row;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        host_req;
    logic [11:0] host_addr;
    logic        host_ack;
    logic [7:0]  host_data;
    logic        host_starved;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] GLYPH_A [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                            8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};

    always #5 clk = ~clk;

    fontrom_arb #(.STARVE_LIMIT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_char(disp_char), .disp_row(disp_row),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .host_req(host_req), .host_addr(host_addr),
        .host_ack(host_ack), .host_data(host_data), .host_starved(host_starved),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    // 128-glyph ROM image; address bit 11 is not decoded
    function automatic logic [7:0] rom_f(input logic [11:0] a);
        if (a[10:4] == 7'h41) return GLYPH_A[a[3:0]];
        if (a[10:0] == 11'h405) return 8'hDE;
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) rom_data <= rom_f(rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; disp_req = 0; disp_char = 0; disp_row = 0; host_req = 0; host_addr = 0;
        tick(); tick();
        checks++;
        if ({disp_valid, disp_data, host_ack, host_data, host_starved, rom_addr} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {disp_valid, disp_data, host_ack, host_data, host_starved, rom_addr});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_disp_single(input logic [3:0] row, input logic [7:0] exp);
        disp_req = 1; disp_char = 8'h41; disp_row = row;
        tick();
        disp_req = 0;
        checks++;
        if (rom_addr !== {8'h41, row}) begin
            errors++; $display("FAIL disp_rom_addr got %h want %h", rom_addr, {8'h41, row});
        end
        tick();
        checks++;
        if (disp_valid !== 1'b0) begin errors++; $display("FAIL disp_early_valid got %b want 0", disp_valid); end
        tick();
        checks++;
        if (disp_valid !== 1'b1 || disp_data !== exp) begin
            errors++; $display("FAIL disp_row%0d got v=%b d=%h want v=1 d=%h", row, disp_valid, disp_data, exp);
        end
        tick();
        checks++;
        if (disp_valid !== 1'b0 || disp_data !== exp) begin
            errors++; $display("FAIL disp_hold got v=%b d=%h want v=0 d=%h", disp_valid, disp_data, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        for (int k = 0; k < 19; k++) begin
            disp_req = (k < 16); disp_char = 8'h41; disp_row = k[3:0];
            tick();
            exp_v = (k >= 2 && k <= 17);
            checks++;
            if (disp_valid !== exp_v || (exp_v && disp_data !== GLYPH_A[k-2])) begin
                errors++;
                $display("FAIL burst_k%0d got v=%b d=%h want v=%b d=%h", k, disp_valid, disp_data,
                         exp_v, exp_v ? GLYPH_A[k-2] : 8'h00);
            end
        end
        disp_req = 0;
    endtask

    task automatic test_host_idle();
        int acks = 0;
        host_req = 1; host_addr = 12'h405;
        tick();
        host_addr = 12'h123;
        checks++;
        if (rom_addr !== 12'h405 || host_ack !== 1'b0) begin
            errors++; $display("FAIL host_grant got a=%h ack=%b want a=405 ack=0", rom_addr, host_ack);
        end
        tick();
        checks++;
        if (host_ack !== 1'b0) begin errors++; $display("FAIL host_early_ack got %b want 0", host_ack); end
        tick();
        checks++;
        if (host_ack !== 1'b1 || host_data !== 8'hDE) begin
            errors++; $display("FAIL host_ack got ack=%b d=%h want ack=1 d=de", host_ack, host_data);
        end
        tick();
        host_req = 0;
        for (int i = 0; i < 6; i++) begin
            acks += int'(host_ack);
            tick();
        end
        checks++;
        if (acks != 0 || host_data !== 8'hDE) begin
            errors++; $display("FAIL host_single_ack got extra=%0d d=%h want extra=0 d=de", acks, host_data);
        end
    endtask

    task automatic test_contention();
        int bad = 0;
        disp_req = 1; disp_char = 8'h20; disp_row = 4'h0;
        host_req = 1; host_addr = 12'h405;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (host_ack !== 1'b0 || rom_addr !== 12'h200) bad++;
            if (k == 61) begin
                checks++;
                if (host_starved !== 1'b0) begin errors++; $display("FAIL starve_early got %b want 0", host_starved); end
            end
            if (k == 67) begin
                checks++;
                if (host_starved !== 1'b1) begin errors++; $display("FAIL starve_rise got %b want 1", host_starved); end
            end
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL contention_no_grant got %0d bad cycles want 0", bad); end
        disp_req = 0;
        tick();
        checks++;
        if (rom_addr !== 12'h405 || host_ack !== 1'b0) begin
            errors++; $display("FAIL contention_grant got a=%h ack=%b want a=405 ack=0", rom_addr, host_ack);
        end
        tick(); tick();
        checks++;
        if (host_ack !== 1'b1 || host_data !== 8'hDE || host_starved !== 1'b0) begin
            errors++; $display("FAIL contention_ack got ack=%b d=%h st=%b want ack=1 d=de st=0",
                               host_ack, host_data, host_starved);
        end
        host_req = 0;
        tick(); tick();
    endtask

    task automatic test_reset_midflight();
        int acks = 0;
        host_req = 1; host_addr = 12'h405;
        tick();
        host_req = 0;
        tick();
        rst_n = 0;
        #1;
        checks++;
        if ({disp_valid, disp_data, host_ack, host_data, host_starved, rom_addr} !== 31'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %h want 0",
                     {disp_valid, disp_data, host_ack, host_data, host_starved, rom_addr});
        end
        tick();
        acks += int'(host_ack);
        tick();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            acks += int'(host_ack);
        end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL midreset_no_ack got %0d want 0", acks); end
        host_req = 1; host_addr = 12'h413;
        tick();
        tick();
        tick();
        checks++;
        if (host_ack !== 1'b1 || host_data !== 8'h38) begin
            errors++; $display("FAIL post_reset_host got ack=%b d=%h want ack=1 d=38", host_ack, host_data);
        end
        host_req = 0;
        tick();
    endtask

    task automatic test_high_blank();
        logic [7:0] exp;
`ifdef FONTROM_ARB_HIGH_BLANK_EN
        exp = 8'h00;
`else
        exp = 8'h38;
`endif
        disp_req = 1; disp_char = 8'hC1; disp_row = 4'd3;
        tick();
        disp_req = 0;
        tick(); tick();
        checks++;
        if (disp_valid !== 1'b1 || disp_data !== exp) begin
            errors++; $display("FAIL high_char got v=%b d=%h want v=1 d=%h", disp_valid, disp_data, exp);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_disp_single(4'd3, 8'h38);
        test_disp_single(4'd7, 8'hFE);
        test_back_to_back();
        test_host_idle();
        test_contention();
        test_reset_midflight();
        test_high_blank();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fontrom_arb.md
Name: fontrom_arb

Overview:
- Two-requester arbiter and sequencer for the single-port font glyph ROM (8-bit rows, 16 rows per glyph, 12-bit address {char[7:0], row[3:0]}, one registered ROM read stage).
- Display fetch path has strict priority: it must never stall, because it feeds the text-mode pixel pipeline.
- Host (CPU/debug) read port uses a req/ack handshake and gets only idle slots.
- Sits between the text renderer / host bus and the font ROM instance at the video top level.

Parameters:
- STARVE_LIMIT, 64: count of consecutive host-pending-but-ungranted cycles at which host_starved asserts (1..255).

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- disp_req  in  1  display fetch request, one per cycle, no backpressure
- disp_char  in  8  display character code
- disp_row  in  4  glyph row 0..15
- disp_valid  out  1  disp_data valid (one-cycle pulse per request)
- disp_data  out  8  glyph row bits, MSB = leftmost pixel
- host_req  in  1  host read request (level)
- host_addr  in  12  host raw ROM address
- host_ack  out  1  one-cycle pulse, host_data valid
- host_data  out  8  host read data
- host_starved  out  1  host waited >= STARVE_LIMIT cycles
- rom_addr  out  12  registered address to font ROM
- rom_data  in  8  font ROM output (valid one cycle after rom_addr is captured)

Behaviour:
- Reset values: all outputs 0; host FSM IDLE; tag pipeline empty; starve counter 0.
- Reset mid-operation clears in-flight tags. Data already in the ROM is discarded; no valid/ack is issued afterwards.
- Slot decision at each rising edge:
  - disp_req=1: rom_addr <= {disp_char, disp_row}; tag DISP.
  - else host FSM IDLE and host_req=1: rom_addr <= host_addr; tag HOST; FSM -> WAIT.
  - else rom_addr holds; tag NONE.
- Tag pipeline: 2 stages (ROM capture, data return). At stage-2 the block registers rom_data into disp_data or host_data according to the tag.
- Latency: disp_req sampled at edge E0 -> disp_valid high in the cycle after E2 (3 cycles). Fully pipelined: back-to-back requests give back-to-back valids.
- disp_data and host_data hold their value between pulses.
- Host FSM:
  - IDLE -> WAIT on grant.
  - WAIT -> ACK when the HOST tag returns; host_ack=1 for that one cycle.
  - ACK -> IDLE unconditionally.
  - host_req is ignored during WAIT and ACK. The host must drop host_req in its ack cycle; a req still high in the following IDLE cycle is a new transaction.
  - host_addr is captured at grant and may change afterwards.
- Starve counter:
  - Increments each edge where the FSM is IDLE, host_req=1 and disp_req=1.
  - Saturates at 255.
  - Clears on host grant or when host_req=0.
  - host_starved = (counter >= STARVE_LIMIT), registered.
- Simultaneous disp_req and host_req: display wins every time. The host waits indefinitely; no fairness forcing, since the display path must not stall.

Optional Feature:
- FONTROM_ARB_HIGH_BLANK_EN defined: display requests with disp_char[7]=1 still consume a slot and keep the 3-cycle timing, but return disp_data=8'h00. The ROM image holds 128 glyphs, and the ROM ignores address bit 11, so these codes would otherwise alias glyphs 0x00-0x7F. Host reads are unaffected.
- Not defined: the address is passed unchanged and codes 0x80-0xFF alias.

Decomposition:
- Shared package fontrom_pkg:
  - owner enum {NONE, DISP, HOST}
  - host FSM state enum {IDLE, WAIT, ACK}
  - GLYPH_ROWS=16, FONT_ADDR_W=12, FONT_DATA_W=8
  - function glyph_addr(char, row)
- No sub-module. The ROM is instantiated beside this block at top level; the tag pipeline is inline.

Test Plan:
- Display 'A' row 3 (with the real font ROM): disp_req with char 0x41, row 3 -> rom_addr=0x413 one edge later; disp_valid 3 cycles after the request with disp_data=0x38. Row 7 returns 0xFE.
- Burst: 16 consecutive disp_req for char 0x41, rows 0..15 -> 16 consecutive disp_valid pulses. Data is 00,00,10,38,6C,C6,C6,FE,C6,C6,C6,C6,00,00,00,00, with no gaps.
- Host on an idle bus: host_req with addr 0x405 -> host_ack exactly 3 cycles later with host_data=0xDE. Holding host_req through the ack cycle yields exactly one ack.
- Contention: disp_req held for 100 cycles while host_req is pending, STARVE_LIMIT=64 -> no host grant during the burst. host_starved rises after 64 cycles; host_ack comes 3 cycles after disp_req drops; the counter then clears.
- Reset mid-flight: assert rst_n low one cycle after a host grant -> host_ack never pulses, all outputs go to 0, and the next request works normally.
- FONTROM_ARB_HIGH_BLANK_EN: disp char 0xC1 row 3 -> disp_data=0x00 at the normal latency. Without the macro -> 0x38.
